led_pattern_player: RTL and testbench

- Parametrised successor to the team's fixed 8-LED Simon blinker.
- Plays a programmable sequence of single-LED steps from a small writable pattern memory, with configurable LED count, sequence depth, tick prescaler and ON/OFF durations.
- Supports one-shot and loop modes, a WIN display (all LEDs on) and a FAIL display (all LEDs blinking).
- Sits between the game-control FSM (start/stop/correct/wrong) and the board LED pins.

---
 rtl/led_pattern_player.sv | 163 ++++++++++++++++
 tb/tb_led_pattern_player.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_player.sv
// Single-LED pattern sequencer between the game-control FSM and the board LEDs.
// Plays steps from a writable pattern memory and shows WIN (all on) / FAIL (all blinking).
module led_pattern_player #(
   parameter int unsigned N_LED       = 8,
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned TICK_DIV    = 4,
   parameter int unsigned ON_TICKS    = 2,
   parameter int unsigned OFF_TICKS   = 1,
   parameter int unsigned FAIL_BLINKS = 3,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned IW = (N_LED > 2) ? $clog2(N_LED) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             loop_mode,
   input  logic [AW-1:0]    len_m1,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [IW-1:0]    wr_data,
   input  logic             correct,
   input  logic             wrong,
   output logic [N_LED-1:0] led,
   output logic             busy,
   output logic             done,
   output logic [AW-1:0]    step_idx
);

   localparam int unsigned FAIL_TICKS = 2 * FAIL_BLINKS;
   localparam int unsigned ONOFF_MAX  = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int unsigned PH_MAX     = (ONOFF_MAX > FAIL_TICKS) ? ONOFF_MAX : FAIL_TICKS;
   localparam int unsigned PW         = $clog2(PH_MAX + 1);
   localparam int unsigned DW         = $clog2(TICK_DIV + 1);

   typedef enum logic [2:0] {StIdle, StOff, StOn, StWin, StFail} state_e;

   state_e           state;
   logic [IW-1:0]    pattern [DEPTH];
   logic [DW-1:0]    presc;
   logic [PW-1:0]    phase;
   logic [AW-1:0]    len_q;
   logic             loop_q;
   logic             tick;
   logic [IW-1:0]    cur_entry;
   logic [N_LED-1:0] led_hot;

   assign cur_entry = pattern[step_idx];
   assign tick      = (presc == DW'(TICK_DIV - 1));

   // Entries >= N_LED decode to no LED at all.
   always_comb begin
      led_hot = '0;
      for (int i = 0; i < int'(N_LED); i++) begin
         if (cur_entry == IW'(i)) led_hot[i] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) pattern[i] <= IW'(i % int'(N_LED));
      end else if (wr_en) begin
         pattern[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= StIdle;
         led      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         step_idx <= '0;
         presc    <= '0;
         phase    <= '0;
         len_q    <= '0;
         loop_q   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (correct) begin
            state <= StWin;
            led   <= '1;
            busy  <= 1'b0;
            presc <= '0;
            phase <= '0;
         end else if (wrong && state != StWin) begin
            state <= StFail;
            led   <= '1;
            busy  <= 1'b1;
            presc <= '0;
            phase <= '0;
         end else if (stop && (state == StOff || state == StOn)) begin
            state <= StIdle;
            led   <= '0;
            busy  <= 1'b0;
            presc <= '0;
            phase <= '0;
         end else if (start) begin
            state    <= StOff;
            led      <= '0;
            busy     <= 1'b1;
            presc    <= '0;
            phase    <= '0;
            step_idx <= '0;
            len_q    <= len_m1;
            loop_q   <= loop_mode;
         end else begin
            if (state == StOff || state == StOn || state == StFail) begin
               presc <= tick ? '0 : presc + DW'(1);
            end
            case (state)
               StOff: begin
                  if (tick) begin
                     if (phase == PW'(OFF_TICKS - 1)) begin
                        state <= StOn;
                        phase <= '0;
                        led   <= led_hot;
                     end else begin
                        phase <= phase + PW'(1);
                     end
                  end
               end
               StOn: begin
                  if (tick) begin
                     if (phase == PW'(ON_TICKS - 1)) begin
                        phase <= '0;
                        led   <= '0;
                        if (step_idx < len_q) begin
                           step_idx <= step_idx + AW'(1);
                           state    <= StOff;
                        end else if (loop_q) begin
                           step_idx <= '0;
                           state    <= StOff;
                        end else begin
                           state <= StIdle;
                           busy  <= 1'b0;
                           done  <= 1'b1;
                        end
                     end else begin
                        phase <= phase + PW'(1);
                     end
                  end
               end
               StFail: begin
                  if (tick) begin
                     if (phase == PW'(FAIL_TICKS - 1)) begin
                        state <= StIdle;
                        phase <= '0;
                        led   <= '0;
                        busy  <= 1'b0;
                     end else begin
                        phase <= phase + PW'(1);
                        led   <= ~led;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_led_pattern_player.sv
// Scoreboard bench: stimulus queues expected LED runs and done times, a monitor checks them.
module tb_led_pattern_player;

   logic       clk = 1'b0;
   logic       rst_n, start, stop, loop_mode, wr_en, correct, wrong;
   logic [2:0] len_m1, wr_addr, wr_data;
   logic [7:0] led_a;
   logic [5:0] led_b;
   logic       busy_a, done_a, busy_b, done_b;
   logic [2:0] step_a, step_b;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int start_k;

   typedef struct {logic [7:0] val; int len;} run_t;
   run_t run_q[$];
   int   done_q[$];

   logic       sel = 1'b0;
   logic       arm = 1'b0;
   logic       active = 1'b0;
   logic [7:0] m_led;
   logic       m_done;
   logic [7:0] run_val;
   int         run_len;

   assign m_led  = sel ? {2'b00, led_b} : led_a;
   assign m_done = sel ? done_b : done_a;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   led_pattern_player #(
      .N_LED(8), .DEPTH(8), .TICK_DIV(2), .ON_TICKS(2), .OFF_TICKS(1), .FAIL_BLINKS(3)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_mode(loop_mode),
      .len_m1(len_m1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .correct(correct), .wrong(wrong), .led(led_a), .busy(busy_a), .done(done_a),
      .step_idx(step_a)
   );

   led_pattern_player #(
      .N_LED(6), .DEPTH(8), .TICK_DIV(2), .ON_TICKS(2), .OFF_TICKS(1), .FAIL_BLINKS(3)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_mode(loop_mode),
      .len_m1(len_m1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .correct(correct), .wrong(wrong), .led(led_b), .busy(busy_b), .done(done_b),
      .step_idx(step_b)
   );

   // Monitor: splits the selected LED stream into constant-value runs and scores each one.
   initial begin
      run_t r;
      forever begin
         @(negedge clk);
         if (arm) begin
            arm     = 1'b0;
            active  = 1'b1;
            run_val = m_led;
            run_len = 1;
         end else if (active) begin
            if (m_led === run_val) begin
               run_len++;
            end else begin
               checks++;
               if (run_q.size() == 0) begin
                  errors++;
                  $display("FAIL run: got led=%02h len=%0d, expected no further run",
                           run_val, run_len);
               end else begin
                  r = run_q.pop_front();
                  if (r.val !== run_val || r.len != run_len) begin
                     errors++;
                     $display("FAIL run: got led=%02h len=%0d, expected led=%02h len=%0d",
                              run_val, run_len, r.val, r.len);
                  end
               end
               run_val = m_led;
               run_len = 1;
            end
         end
         if (active && m_done === 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin
               errors++;
               $display("FAIL done: got pulse %0d cycles after start, expected none",
                        cyc - start_k);
            end else if (done_q.pop_front() != cyc - start_k) begin
               errors++;
               $display("FAIL done: got pulse %0d cycles after start, expected 48",
                        cyc - start_k);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected simulation to complete");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic write_pat(input logic [2:0] a, input logic [2:0] d);
      int c;
      c       = cyc;
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      wait_cyc(c + 1);
      wr_en   = 1'b0;
   endtask

   task automatic start_play(input logic [2:0] len, input logic lp, input logic do_arm);
      int c;
      c         = cyc;
      len_m1    = len;
      loop_mode = lp;
      start     = 1'b1;
      wait_cyc(c + 1);
      start     = 1'b0;
      start_k   = cyc;
      arm       = do_arm;
   endtask

   task automatic push_run(input logic [7:0] v, input int n);
      run_q.push_back('{val: v, len: n});
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic end_test(input string name);
      check({name, "_runs_left"}, run_q.size(), 0);
      check({name, "_done_left"}, done_q.size(), 0);
      active = 1'b0;
   endtask

   initial begin
      int k;
      int pat1[8] = '{1, 5, 0, 7, 2, 6, 3, 4};
      rst_n = 1'b0; start = 0; stop = 0; loop_mode = 0; wr_en = 0; correct = 0; wrong = 0;
      len_m1 = '0; wr_addr = '0; wr_data = '0;
      @(posedge clk);
      #1;
      check("rst_led", led_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_step", step_a, 0);
      rst_n = 1'b1;
      wait_cyc(cyc + 2);

      // 1: one-shot playback of a written pattern
      for (int i = 0; i < 8; i++) write_pat(3'(i), 3'(pat1[i]));
      for (int i = 0; i < 8; i++) begin
         push_run(8'h00, 2);
         push_run(8'h01 << pat1[i], 4);
      end
      done_q.push_back(48);
      start_play(3'd7, 1'b0, 1'b1);
      k = start_k;
      wait_cyc(k + 50);
      check("t1_led_idle", led_a, 0);
      check("t1_busy_idle", busy_a, 0);
      end_test("t1");

      // 2: loop wrap on default pattern; len/loop changes mid-play are ignored
      pulse_reset();
      for (int p = 0; p < 3; p++) begin
         for (int s = 0; s < 3; s++) begin
            push_run(8'h00, 2);
            push_run(8'h01 << s, 4);
         end
      end
      start_play(3'd2, 1'b1, 1'b1);
      k = start_k;
      len_m1    = 3'd7;
      loop_mode = 1'b0;
      wait_cyc(k + 17);
      check("t2_step_before_wrap", step_a, 2);
      check("t2_led_step2", led_a, 8'h04);
      wait_cyc(k + 18);
      check("t2_step_after_wrap", step_a, 0);
      wait_cyc(k + 54);
      stop = 1'b1;
      wait_cyc(k + 55);
      stop = 1'b0;
      check("t2_busy_stop", busy_a, 0);
      check("t2_led_stop", led_a, 0);
      end_test("t2");

      // 3: correct and wrong together mid-ON -> WIN, held until start
      push_run(8'h00, 2);
      push_run(8'h01, 1);
      push_run(8'hFF, 100);
      push_run(8'h00, 2);
      push_run(8'h01, 4);
      start_play(3'd7, 1'b0, 1'b1);
      k = start_k;
      wait_cyc(k + 2);
      correct = 1'b1;
      wrong   = 1'b1;
      wait_cyc(k + 3);
      correct = 1'b0;
      wrong   = 1'b0;
      check("t3_win_led", led_a, 8'hFF);
      check("t3_win_busy", busy_a, 0);
      wait_cyc(k + 60);
      check("t3_win_hold", led_a, 8'hFF);
      wait_cyc(k + 102);
      start = 1'b1;
      wait_cyc(k + 103);
      start = 1'b0;
      check("t3_restart_step", step_a, 0);
      check("t3_restart_busy", busy_a, 1);
      wait_cyc(k + 109);
      stop = 1'b1;
      wait_cyc(k + 110);
      stop = 1'b0;
      end_test("t3");

      // 4: wrong during OFF -> three blink pairs then IDLE
      push_run(8'h00, 1);
      for (int i = 0; i < 3; i++) begin
         push_run(8'hFF, 2);
         if (i < 2) push_run(8'h00, 2);
      end
      start_play(3'd7, 1'b0, 1'b1);
      k = start_k;
      wrong = 1'b1;
      wait_cyc(k + 1);
      wrong = 1'b0;
      check("t4_fail_busy", busy_a, 1);
      wait_cyc(k + 12);
      check("t4_fail_busy_late", busy_a, 1);
      wait_cyc(k + 13);
      check("t4_end_busy", busy_a, 0);
      check("t4_end_led", led_a, 0);
      wait_cyc(k + 16);
      end_test("t4");

      // 5: N_LED=6 instance, out-of-range entry and write to the displayed step
      sel = 1'b1;
      write_pat(3'd0, 3'd7);
      push_run(8'h00, 8);
      push_run(8'h02, 4);
      push_run(8'h00, 8);
      push_run(8'h08, 4);
      start_play(3'd1, 1'b1, 1'b1);
      k = start_k;
      wait_cyc(k + 3);
      check("t5_oor_busy", busy_b, 1);
      check("t5_oor_led", led_b, 0);
      wait_cyc(k + 8);
      write_pat(3'd1, 3'd3);
      check("t5_keep_old_led", led_b, 6'h02);
      wait_cyc(k + 21);
      check("t5_new_led", led_b, 6'h08);
      wait_cyc(k + 24);
      stop = 1'b1;
      wait_cyc(k + 25);
      stop = 1'b0;
      end_test("t5");
      sel = 1'b0;

      // 6: asynchronous reset at step 4 ON, then pattern is back to defaults
      start_play(3'd7, 1'b0, 1'b0);
      k = start_k;
      wait_cyc(k + 27);
      check("t6_pre_step", step_a, 4);
      check("t6_pre_led", led_a, 8'h10);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_async_led", led_a, 0);
      check("t6_async_busy", busy_a, 0);
      check("t6_async_step", step_a, 0);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         push_run(8'h00, 2);
         push_run(8'h01 << i, 4);
      end
      done_q.push_back(48);
      start_play(3'd7, 1'b0, 1'b1);
      k = start_k;
      wait_cyc(k + 50);
      check("t6_led_idle", led_a, 0);
      end_test("t6");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
